// File: rtl/popcount_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_accumulator
//  Description : Sums the 4-bit column counts from the 13-input adder stage
//                over a frame delimited by in_last. The frame total is
//                presented on a valid/ready result port. The sum and the
//                beat count both saturate, and out_ovf records that either
//                one saturated.
//                Optional macro POPCOUNT_ACC_DOT_EN adds a signed out_dot
//                output equal to 2*out_sum - 13*out_beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount_accumulator #(
    parameter int ACC_W  = 16,
    parameter int BEAT_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_cnt,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [BEAT_W-1:0] out_beats,
    output logic              out_ovf
`ifdef POPCOUNT_ACC_DOT_EN
    ,
    output logic signed [ACC_W+BEAT_W+1:0] out_dot
`endif
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACC  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              ready_q;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic              ovf_q, ovf_d;

    logic              w_accept;
    logic [ACC_W:0]    w_acc_sum;

    assign w_accept  = in_valid & ready_q;
    assign w_acc_sum = {1'b0, acc_q} + {{(ACC_W-3){1'b0}}, in_cnt};

    // Frame sequencing: open on the first beat, close on in_last, then hold the result until it is taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: if (w_accept) state_d = in_last ? c_DONE : c_ACC;
            c_ACC:  if (w_accept && in_last) state_d = c_DONE;
            c_DONE: if (out_ready) state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // Datapath next state: load on the first beat of a frame, saturating add otherwise
    always_comb begin
        acc_d   = acc_q;
        beats_d = beats_q;
        ovf_d   = ovf_q;
        if (w_accept) begin
            if (state_q == c_IDLE) begin
                acc_d   = {{(ACC_W-4){1'b0}}, in_cnt};
                beats_d = BEAT_W'(1);
                ovf_d   = 1'b0;
            end else begin
                if (w_acc_sum[ACC_W]) begin
                    acc_d = '1;
                    ovf_d = 1'b1;
                end else begin
                    acc_d = w_acc_sum[ACC_W-1:0];
                end
                if (&beats_q) begin
                    ovf_d = 1'b1;
                end else begin
                    beats_d = beats_q + BEAT_W'(1);
                end
            end
        end
    end

    // State, ready and accumulator registers; ready is registered so it is low throughout reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= c_IDLE;
            ready_q <= 1'b0;
            acc_q   <= '0;
            beats_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != c_DONE);
            acc_q   <= acc_d;
            beats_q <= beats_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state_q == c_DONE);
    assign out_sum   = acc_q;
    assign out_beats = beats_q;
    assign out_ovf   = ovf_q;

`ifdef POPCOUNT_ACC_DOT_EN
    localparam int DOT_W = ACC_W + BEAT_W + 2;

    logic signed [DOT_W-1:0] dot_q, w_dot_d;
    logic signed [DOT_W-1:0] w_sum_x, w_beats_x;

    // Map the popcount of matches onto a +/-1 dot product: 2*sum - 13*beats, with no saturation
    always_comb begin
        w_sum_x   = {{(DOT_W-ACC_W){1'b0}}, acc_d};
        w_beats_x = {{(DOT_W-BEAT_W){1'b0}}, beats_d};
        w_dot_d   = (w_sum_x <<< 1) - ((w_beats_x <<< 3) + (w_beats_x <<< 2) + w_beats_x);
    end

    // The dot product register follows the accumulator, so it holds exactly as out_sum does
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dot_q <= '0;
        end else if (w_accept) begin
            dot_q <= w_dot_d;
        end
    end

    assign out_dot = dot_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_popcount_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_popcount_accumulator
//  Description : Directed bench for popcount_accumulator. Instance u_dut uses
//                the default widths. Instance u_sat uses ACC_W=5 and BEAT_W=2
//                so that sum and beat-count saturation are reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_popcount_accumulator;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic [3:0] in_cnt;
    logic       in_last;
    logic       out_ready;

    logic        d_in_ready, d_out_valid, d_out_ovf;
    logic [15:0] d_out_sum;
    logic [7:0]  d_out_beats;

    logic        s_in_ready, s_out_valid, s_out_ovf;
    logic [4:0]  s_out_sum;
    logic [1:0]  s_out_beats;

`ifdef POPCOUNT_ACC_DOT_EN
    logic signed [25:0] d_out_dot;
    logic signed [8:0]  s_out_dot;
`endif

    int n_checks;
    int n_errors;

    popcount_accumulator #(.ACC_W(16), .BEAT_W(8)) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (d_in_ready),
        .in_cnt    (in_cnt),
        .in_last   (in_last),
        .out_valid (d_out_valid),
        .out_ready (out_ready),
        .out_sum   (d_out_sum),
        .out_beats (d_out_beats),
        .out_ovf   (d_out_ovf)
`ifdef POPCOUNT_ACC_DOT_EN
        ,
        .out_dot   (d_out_dot)
`endif
    );

    popcount_accumulator #(.ACC_W(5), .BEAT_W(2)) u_sat (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_cnt    (in_cnt),
        .in_last   (in_last),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_sum   (s_out_sum),
        .out_beats (s_out_beats),
        .out_ovf   (s_out_ovf)
`ifdef POPCOUNT_ACC_DOT_EN
        ,
        .out_dot   (s_out_dot)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until it is accepted (bounded wait on in_ready)
    task automatic send_beat(input logic [3:0] cnt, input logic last);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_cnt   = cnt;
        in_last  = last;
        while (!d_in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!d_in_ready) check("beat_ready_timeout", {63'b0, d_in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_cnt    = 4'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  {63'b0, d_in_ready},  64'd0);
        check("rst_out_valid", {63'b0, d_out_valid}, 64'd0);
        check("rst_out_sum",   64'(d_out_sum),       64'd0);
        check("rst_out_beats", 64'(d_out_beats),     64'd0);
        check("rst_out_ovf",   {63'b0, d_out_ovf},   64'd0);
        #3 reset_n = 1'b1;
        tick();
        check("post_rst_in_ready", {63'b0, d_in_ready}, 64'd1);

        // Single-beat frame
        send_beat(4'd13, 1'b1);
        check("single_valid", {63'b0, d_out_valid}, 64'd1);
        check("single_sum",   64'(d_out_sum),       64'd13);
        check("single_beats", 64'(d_out_beats),     64'd1);
        check("single_ovf",   {63'b0, d_out_ovf},   64'd0);
        check("single_ready", {63'b0, d_in_ready},  64'd0);
`ifdef POPCOUNT_ACC_DOT_EN
        check("single_dot",   64'(d_out_dot),       64'd13);
`endif
        tick();
        check("single_hs_valid", {63'b0, d_out_valid}, 64'd0);
        check("single_hs_ready", {63'b0, d_in_ready},  64'd1);
        check("single_hs_sum",   64'(d_out_sum),       64'd13);

        // Four-beat frame; u_sat also saturates its 2-bit beat counter here
        send_beat(4'd5,  1'b0);
        send_beat(4'd0,  1'b0);
        send_beat(4'd13, 1'b0);
        send_beat(4'd7,  1'b1);
        check("four_sum",       64'(d_out_sum),       64'd25);
        check("four_beats",     64'(d_out_beats),     64'd4);
        check("four_ovf",       {63'b0, d_out_ovf},   64'd0);
        check("four_ready",     {63'b0, d_in_ready},  64'd0);
        check("sat4_sum",       64'(s_out_sum),       64'd25);
        check("sat4_beats",     64'(s_out_beats),     64'd3);
        check("sat4_ovf",       {63'b0, s_out_ovf},   64'd1);
`ifdef POPCOUNT_ACC_DOT_EN
        check("four_dot",       64'(d_out_dot),       -64'sd2);
        check("sat4_dot",       64'(s_out_dot),       64'd11);
`endif
        tick();
        check("four_hs_valid", {63'b0, d_out_valid}, 64'd0);
        check("four_hs_ready", {63'b0, d_in_ready},  64'd1);

        // Backpressure: result held for five cycles, then one handshake
        out_ready = 1'b0;
        send_beat(4'd6, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {63'b0, d_out_valid}, 64'd1);
            check("bp_sum",   64'(d_out_sum),       64'd6);
            check("bp_ready", {63'b0, d_in_ready},  64'd0);
            tick();
        end
        out_ready = 1'b1;
        check("bp_last_valid", {63'b0, d_out_valid}, 64'd1);
        tick();
        check("bp_hs_valid", {63'b0, d_out_valid}, 64'd0);
        check("bp_hs_ready", {63'b0, d_in_ready},  64'd1);

        // Sum saturation on the 5-bit accumulator, then a clean next frame
        send_beat(4'd13, 1'b0);
        send_beat(4'd13, 1'b0);
        send_beat(4'd13, 1'b1);
        check("sat_sum",   64'(s_out_sum),      64'd31);
        check("sat_ovf",   {63'b0, s_out_ovf},  64'd1);
        check("sat_beats", 64'(s_out_beats),    64'd3);
        check("wide_sum",  64'(d_out_sum),      64'd39);
        check("wide_ovf",  {63'b0, d_out_ovf},  64'd0);
`ifdef POPCOUNT_ACC_DOT_EN
        check("sat_dot",   64'(s_out_dot),      64'd23);
`endif
        tick();
        send_beat(4'd2, 1'b1);
        check("after_sat_sum", 64'(s_out_sum),     64'd2);
        check("after_sat_ovf", {63'b0, s_out_ovf}, 64'd0);
        tick();

        // Gaps between beats keep the frame open
        send_beat(4'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("gap_valid", {63'b0, d_out_valid}, 64'd0);
            check("gap_ready", {63'b0, d_in_ready},  64'd1);
            tick();
        end
        send_beat(4'd4, 1'b1);
        check("gap_sum",   64'(d_out_sum),   64'd7);
        check("gap_beats", 64'(d_out_beats), 64'd2);
        tick();

        // Asynchronous reset in the middle of a frame
        send_beat(4'd9, 1'b0);
        send_beat(4'd9, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_sum",   64'(d_out_sum),      64'd0);
        check("mid_rst_ready", {63'b0, d_in_ready}, 64'd0);
        #2 reset_n = 1'b1;
        tick();
        check("mid_rst_valid", {63'b0, d_out_valid}, 64'd0);
        check("mid_rst_rdy1",  {63'b0, d_in_ready},  64'd1);
        send_beat(4'd1, 1'b1);
        check("post_rst_valid", {63'b0, d_out_valid}, 64'd1);
        check("post_rst_sum",   64'(d_out_sum),       64'd1);
        check("post_rst_beats", 64'(d_out_beats),     64'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
